// File: rtl/tone_pkg.sv
// Shared definitions for the scale-driven square-wave generator and the
// frequency-adjust block that feeds it.
package tone_pkg;

    // Width of the Scale word exchanged with the adjust block.
    localparam int TONE_SCALE_W  = 6;

    // Default number of sysclk cycles per scale unit.
    localparam int TONE_BASE_DIV = 4;

    // Generator FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HIGH = 2'd1;
    localparam state_t ST_LOW  = 2'd2;

endpackage

// File: rtl/half_period_counter.sv
// Up-counter timing one half-period of the tone. It raises a terminal-count
// flag when the count equals the supplied terminal value (H-1) and is
// returned to zero by a synchronous clear.
module half_period_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;

    // Count every cycle; clear restarts the half-period at zero.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tc = (count_reg == term);

endmodule

// File: rtl/scale_tone_gen.sv
// Square-wave generator driven by the Scale word. The half-period is
// (ScaleActive + 1) * BASE_DIV cycles; new Scale values are taken only at
// full-period boundaries so the output never produces a runt phase.
module scale_tone_gen
    import tone_pkg::*;
#(
    parameter int SCALE_W  = TONE_SCALE_W,
    parameter int BASE_DIV = TONE_BASE_DIV,
    parameter int CNT_W    = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Enable,
    input  logic [SCALE_W-1:0] Scale,
    output logic               Tone,
    output logic               Tick,
    output logic [SCALE_W-1:0] ScaleActive
);

    // One extra bit so that (2^SCALE_W) * BASE_DIV == 2^CNT_W does not wrap
    // before the terminal value H-1 is formed.
    localparam logic [CNT_W:0] BASE_DIV_W = (CNT_W+1)'(BASE_DIV);
    localparam logic [CNT_W:0] ONE_W      = (CNT_W+1)'(1);

    state_t             state_reg;
    logic               tone_reg;
    logic               tick_reg;
    logic [SCALE_W-1:0] scale_active_reg;

    logic [CNT_W:0]     half_period;
    logic [CNT_W-1:0]   term;
    logic               tc;
    logic               cnt_clear;

    // Half-period length and its terminal count from the latched scale.
    always_comb begin
        half_period = ((CNT_W+1)'(scale_active_reg) + ONE_W) * BASE_DIV_W;
        term        = CNT_W'(half_period - ONE_W);
    end

    // Hold the counter at zero while idle and restart it at every phase end.
    assign cnt_clear = (state_reg == ST_IDLE) || tc;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk   (sysclk),
        .srst  (reset),
        .clear (cnt_clear),
        .term  (term),
        .tc    (tc)
    );

    // Generator FSM: start/restart latches Scale and raises Tone with Tick.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            tone_reg         <= 1'b0;
            tick_reg         <= 1'b0;
            scale_active_reg <= '0;
        end else begin
            tick_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Enable) begin
                        scale_active_reg <= Scale;
                        state_reg        <= ST_HIGH;
                        tone_reg         <= 1'b1;
                        tick_reg         <= 1'b1;
                    end else begin
                        tone_reg <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        state_reg <= ST_LOW;
                        tone_reg  <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (tc) begin
                        if (Enable) begin
                            scale_active_reg <= Scale;
                            state_reg        <= ST_HIGH;
                            tone_reg         <= 1'b1;
                            tick_reg         <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tone_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Tone        = tone_reg;
    assign Tick        = tick_reg;
    assign ScaleActive = scale_active_reg;

endmodule

// File: tb/tb_scale_tone_gen.sv
// Directed bench for scale_tone_gen with BASE_DIV = 4: steady-period table
// plus hand-written sequences for scale changes, stop, reset and bursts.
module tb_scale_tone_gen;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       enable;
    logic [5:0] scale;
    logic       tone;
    logic       tick;
    logic [5:0] scale_active;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [5:0] scale;
        int         half;
    } vec_t;

    vec_t vecs[5];

    int         hi, lo, tk;
    logic [5:0] sa;
    bit         rose, ok;

    scale_tone_gen #(
        .SCALE_W  (6),
        .BASE_DIV (4),
        .CNT_W    (16)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .Enable      (enable),
        .Scale       (scale),
        .Tone        (tone),
        .Tick        (tick),
        .ScaleActive (scale_active)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for a cycle where Tone and Tick are both high.
    task automatic wait_rise(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tone && tick) begin
                found = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
    endtask

    // Called on the first cycle of a high phase; measures one full period and
    // returns on the first cycle of the next high phase (or at lo_bound).
    task automatic measure_period(input int chg_at, input int chg_n, input logic [5:0] chg_step,
                                  input int drop_at, input int lo_bound,
                                  output int hi_o, output int lo_o, output logic [5:0] sa_o,
                                  output int ticks_o, output bit rose_o);
        sa_o = scale_active;
        hi_o = 0;
        lo_o = 0;
        ticks_o = 0;
        while (tone && hi_o < 1000) begin
            hi_o++;
            if (tick) ticks_o++;
            if (hi_o >= chg_at && hi_o < chg_at + chg_n) scale = scale + chg_step;
            if (hi_o == drop_at) enable = 1'b0;
            @(negedge sysclk);
        end
        while (!tone && lo_o < lo_bound) begin
            lo_o++;
            if (tick) ticks_o++;
            @(negedge sysclk);
        end
        rose_o = tone && tick;
    endtask

    task automatic start_gen(input logic [5:0] s);
        reset  = 1'b1;
        scale  = s;
        enable = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        vecs[0] = '{6'd0,  4};
        vecs[1] = '{6'd3,  16};
        vecs[2] = '{6'd7,  32};
        vecs[3] = '{6'd10, 44};
        vecs[4] = '{6'd63, 256};

        // Reset held 3 cycles with Enable high: outputs stay at reset values.
        reset  = 1'b1;
        enable = 1'b1;
        scale  = 6'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            chk("reset_tone", tone, 0);
            chk("reset_tick", tick, 0);
            chk("reset_scale_active", scale_active, 0);
        end
        reset = 1'b0;
        @(negedge sysclk);
        chk("start_latency_tone", tone, 1);
        chk("start_latency_tick", tick, 1);
        $display("reset hold: tone=%0d tick=%0d after release", tone, tick);

        // Steady periods: two back-to-back periods per scale value.
        for (int v = 0; v < 5; v++) begin
            start_gen(vecs[v].scale);
            wait_rise(ok);
            chk("steady_first_rise", ok, 1);
            for (int p = 0; p < 2; p++) begin
                measure_period(0, 0, 6'd0, 0, 600, hi, lo, sa, tk, rose);
                chk("steady_high", hi, vecs[v].half);
                chk("steady_low", lo, vecs[v].half);
                chk("steady_scale_active", sa, vecs[v].scale);
                chk("steady_ticks", tk, 1);
                chk("steady_next_rise", rose, 1);
                $display("steady scale=%0d period=%0d: high=%0d low=%0d ticks=%0d", vecs[v].scale, p, hi, lo, tk);
            end
        end

        // Scale 1 -> 5 on cycle 2 of HIGH: adopted only at the next boundary.
        start_gen(6'd1);
        wait_rise(ok);
        chk("change_first_rise", ok, 1);
        measure_period(2, 1, 6'd4, 0, 600, hi, lo, sa, tk, rose);
        chk("change_p0_high", hi, 8);
        chk("change_p0_low", lo, 8);
        chk("change_p0_sa", sa, 1);
        chk("change_p0_rise", rose, 1);
        $display("scale change period0: high=%0d low=%0d sa=%0d", hi, lo, sa);
        measure_period(0, 0, 6'd0, 0, 600, hi, lo, sa, tk, rose);
        chk("change_p1_high", hi, 24);
        chk("change_p1_low", lo, 24);
        chk("change_p1_sa", sa, 5);
        $display("scale change period1: high=%0d low=%0d sa=%0d", hi, lo, sa);

        // Drop Enable on cycle 1 of HIGH: full period, then stays low.
        start_gen(6'd2);
        wait_rise(ok);
        chk("stop_first_rise", ok, 1);
        measure_period(0, 0, 6'd0, 1, 100, hi, lo, sa, tk, rose);
        chk("stop_high", hi, 12);
        chk("stop_low_stays", lo, 100);
        chk("stop_no_rise", rose, 0);
        chk("stop_ticks", tk, 1);
        $display("stop: high=%0d low_observed=%0d ticks=%0d", hi, lo, tk);
        enable = 1'b1;
        @(negedge sysclk);
        chk("restart_tone", tone, 1);
        chk("restart_tick", tick, 1);
        $display("restart from idle: tone=%0d tick=%0d", tone, tick);

        // Reset mid-HIGH with Scale 63, then full-length restart.
        start_gen(6'd63);
        wait_rise(ok);
        chk("midreset_first_rise", ok, 1);
        repeat (10) @(negedge sysclk);
        chk("midreset_in_high", tone, 1);
        reset = 1'b1;
        @(negedge sysclk);
        chk("midreset_tone", tone, 0);
        chk("midreset_tick", tick, 0);
        chk("midreset_sa", scale_active, 0);
        reset = 1'b0;
        @(negedge sysclk);
        chk("midreset_restart_tone", tone, 1);
        measure_period(0, 0, 6'd0, 0, 600, hi, lo, sa, tk, rose);
        chk("midreset_high", hi, 256);
        chk("midreset_low", lo, 256);
        chk("midreset_sa63", sa, 63);
        $display("reset mid-high then restart: high=%0d low=%0d sa=%0d", hi, lo, sa);

        // Burst of 4 increments (2 -> 6) inside one period.
        start_gen(6'd2);
        wait_rise(ok);
        chk("burst_first_rise", ok, 1);
        measure_period(2, 4, 6'd1, 0, 600, hi, lo, sa, tk, rose);
        chk("burst_p0_high", hi, 12);
        chk("burst_p0_low", lo, 12);
        chk("burst_p0_sa", sa, 2);
        measure_period(0, 0, 6'd0, 0, 600, hi, lo, sa, tk, rose);
        chk("burst_p1_high", hi, 28);
        chk("burst_p1_low", lo, 28);
        chk("burst_p1_sa", sa, 6);
        $display("burst: next period high=%0d low=%0d sa=%0d", hi, lo, sa);

        enable = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/scale_tone_gen.md
# scale_tone_gen

Programmable square-wave generator that consumes the 6-bit `Scale` word produced by the Plus/Minus frequency-adjust block and turns it into an audible/observable output frequency. It sits directly downstream of the adjust block on the same `sysclk` domain. New `Scale` values are adopted only at full-period boundaries, so the output never glitches when the user presses Plus or Minus.

## Interface
Parameters:
- `SCALE_W`, default 6: width of `Scale`; must match the adjust block.
- `BASE_DIV`, default 4: `sysclk` cycles per scale unit; must be ≥ 1.
- `CNT_W`, default 16: half-period counter width; must satisfy (2^`SCALE_W`)·`BASE_DIV` ≤ 2^`CNT_W`.

Ports:
- `sysclk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `Enable`  in  1  request to run the generator (level).
- `Scale`  in  `SCALE_W`  frequency setting from the adjust block.
- `Tone`  out  1  square-wave output, registered.
- `Tick`  out  1  one-cycle pulse coincident with every `Tone` rising edge.
- `ScaleActive`  out  `SCALE_W`  the `Scale` value currently in use.

## Operation
- Half-period H = (`ScaleActive` + 1) · `BASE_DIV` cycles, computed in `CNT_W` bits with no truncation. `Scale`=0 gives H=`BASE_DIV`; `Scale`=63 gives H=64·`BASE_DIV`.
- States: IDLE, HIGH, LOW.
- Reset (`reset`=1 at an edge): state=IDLE, `Tone`=0, `Tick`=0, `ScaleActive`=0, count=0. Reset overrides everything, including mid-period operation.
- IDLE, `Enable`=1: latch `Scale` into `ScaleActive`, go to HIGH, set `Tone`=1 and `Tick`=1, count=0.
- IDLE, `Enable`=0: stay in IDLE with `Tone`=0.
- HIGH: count increments each cycle. At count = H−1: go to LOW, `Tone`=0, count=0.
- LOW: count increments each cycle. At count = H−1:
  - `Enable`=1: latch `Scale`, go to HIGH, `Tone`=1, `Tick`=1, count=0.
  - `Enable`=0: go to IDLE.
- `Enable` deasserted during HIGH or LOW: the current period completes in full (no truncated phase), then the block goes to IDLE.
- `Scale` changes during HIGH or LOW are ignored until the next period boundary. Only the value present at the latching edge is used; intermediate values are discarded.
- `Tick` is 0 in all cycles other than those listed above.

## Timing
- Start latency: `Enable` sampled high in IDLE at edge k → `Tone`=1 and `Tick`=1 after edge k.
- `Tone` is high for exactly H cycles and low for exactly H cycles, giving period 2H. Back-to-back periods have no idle gap.
- `Tick` is high for exactly one cycle per period, aligned with the `Tone` rising edge.
- `ScaleActive` updates on the same edge that raises `Tone`.
- Stop: `Tone` stays 0 from the end of the last LOW phase onward. A restart from IDLE incurs one IDLE cycle at minimum.
- Reset asserted at edge k → all outputs at their reset values after edge k, regardless of state.

## Structure
- Shared package `tone_pkg`: state enum (IDLE/HIGH/LOW), the `SCALE_W` constant (shared with the adjust block), and the default `BASE_DIV`.
- One natural sub-module, `half_period_counter`: a loadable up-counter with a terminal-count flag at H−1 and a synchronous clear. The FSM, `Scale` latch and H computation stay in the top module.

## Test plan
All scenarios use `BASE_DIV`=4 unless stated.
- Reset: hold `reset` for 3 cycles with `Enable`=1 → `Tone`=0, `Tick`=0, `ScaleActive`=0 throughout; first `Tone` rise comes 1 edge after `reset` drops.
- `Scale`=0, `Enable`=1 → `Tone` is 4 cycles high and 4 cycles low (period 8); `Tick` pulses every 8 cycles; `Scale`=3 → period 32.
- `Scale`=1 at start; change to 5 on cycle 2 of HIGH → the current period is 8+8; the next period is 24+24; `ScaleActive` changes 1→5 at the second `Tick`.
- Drop `Enable` on cycle 1 of HIGH with `Scale`=2 → `Tone` completes 12 high and 12 low, then stays 0; no further `Tick`.
- Assert `reset` mid-HIGH with `Scale`=63 → `Tone`=0 and state IDLE after that edge; restart with `Scale`=63 → `Tone` is 256 high and 256 low.
- Burst of 4 `Scale` increments within one period → only the value sampled at the next boundary takes effect; period lengths always match (`ScaleActive`+1)·8.
